// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine controller and its phase timer:
// timer state encodings, default widths and nominal phase lengths.
package wash_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10
    } timer_state_e;

    localparam int DEFAULT_CNT_W          = 8;
    localparam int DEFAULT_TICKS_PER_UNIT = 1000;

    // Nominal phase durations used by the controller, in timer units.
    localparam logic [DEFAULT_CNT_W-1:0] FILL_UNITS  = 8'd20;
    localparam logic [DEFAULT_CNT_W-1:0] WASH_UNITS  = 8'd90;
    localparam logic [DEFAULT_CNT_W-1:0] RINSE_UNITS = 8'd45;
    localparam logic [DEFAULT_CNT_W-1:0] SPIN_UNITS  = 8'd30;

endpackage

// File: rtl/wash_phase_timer_if.sv
// Start/done handshake between the washing-machine controller (master)
// and the phase timer (slave).
interface wash_phase_timer_if import wash_pkg::*; #(
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic             start;
    logic [CNT_W-1:0] duration;
    logic             pause_resume;
    logic             abort;
    logic             busy;
    logic             paused;
    logic             done;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, duration, pause_resume, abort,
        input  busy, paused, done, remaining
    );

    modport slave (
        input  start, duration, pause_resume, abort,
        output busy, paused, done, remaining
    );

endinterface

// File: rtl/wash_phase_timer_unit_prescaler.sv
// Divides the clock into time units; tick flags the edge on which the
// prescaler wraps so the owner can act on that same edge.
module unit_prescaler import wash_pkg::*; #(
    parameter int TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_UNIT - 1);

    logic [PW-1:0] presc;

    // Holding en low freezes progress, so a pause keeps the partial unit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == LAST) ? '0 : presc + 1'b1;
        end
    end

    assign tick = en && (presc == LAST);

endmodule

// File: rtl/wash_phase_timer.sv
// Phase countdown timer: counts a loaded duration in prescaled units with
// pause/resume and abort, and pulses done when the count expires.
module wash_phase_timer import wash_pkg::*; #(
    parameter int TICKS_PER_UNIT = DEFAULT_TICKS_PER_UNIT,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input logic              clk,
    input logic              rst,
    wash_phase_timer_if.slave bus
);

    timer_state_e     state;
    logic [CNT_W-1:0] remaining;
    logic             done;
    logic             tick;
    logic             run_en;
    logic             presc_clr;
    logic             expiry;

    assign run_en    = (state == RUN);
    assign presc_clr = bus.start || bus.abort;
    assign expiry    = run_en && tick && (remaining == CNT_W'(1));

    unit_prescaler #(
        .TICKS_PER_UNIT(TICKS_PER_UNIT)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    // Priority is abort > start > expiry > pause_resume; a start on the
    // expiry edge restarts the phase and swallows the expired done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.abort) begin
                state     <= IDLE;
                remaining <= '0;
            end else if (bus.start) begin
                remaining <= bus.duration;
                if (bus.duration != '0) begin
                    state <= RUN;
                end else begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RUN: begin
                        if (expiry) begin
                            remaining <= '0;
                            state     <= IDLE;
                            done      <= 1'b1;
                        end else begin
                            if (tick && (remaining != '0)) begin
                                remaining <= remaining - 1'b1;
                            end
                            if (bus.pause_resume) begin
                                state <= PAUSED;
                            end
                        end
                    end
                    PAUSED: begin
                        if (bus.pause_resume) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = (state == RUN) || (state == PAUSED);
    assign bus.paused    = (state == PAUSED);
    assign bus.done      = done;
    assign bus.remaining = remaining;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Bench for wash_phase_timer: two instances (4 and 1 ticks per unit) share
// one stimulus stream and are compared every cycle against a cycle-budget model.
module tb_wash_phase_timer;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          st  = 1'b0;
    logic          pr  = 1'b0;
    logic          ab  = 1'b0;
    logic [CW-1:0] dur = '0;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;
    int done_cnt;

    wash_phase_timer_if #(.CNT_W(CW)) bus4 ();
    wash_phase_timer_if #(.CNT_W(CW)) bus1 ();

    assign bus4.start        = st;
    assign bus4.duration     = dur;
    assign bus4.pause_resume = pr;
    assign bus4.abort        = ab;
    assign bus1.start        = st;
    assign bus1.duration     = dur;
    assign bus1.pause_resume = pr;
    assign bus1.abort        = ab;

    wash_phase_timer #(.TICKS_PER_UNIT(4), .CNT_W(CW)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    wash_phase_timer #(.TICKS_PER_UNIT(1), .CNT_W(CW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    // Model: a phase is a budget of running cycles (D*T); the display shows
    // the budget rounded up to whole units, and the phase ends when it hits 0.
    bit m_busy   [2] = '{1'b0, 1'b0};
    bit m_paused [2] = '{1'b0, 1'b0};
    bit m_done   [2] = '{1'b0, 1'b0};
    int m_left   [2] = '{0, 0};
    int tpu      [2] = '{4, 1};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic bit nb = m_busy[i];
            automatic bit np = m_paused[i];
            automatic bit nd = 1'b0;
            automatic int nl = m_left[i];
            if (rst || ab) begin
                nb = 1'b0; np = 1'b0; nl = 0;
            end else if (st) begin
                nl = int'(dur) * tpu[i];
                np = 1'b0;
                nb = (dur != 0);
                nd = (dur == 0);
            end else if (m_busy[i] && !m_paused[i]) begin
                nl = nl - 1;
                if (nl == 0) begin
                    nb = 1'b0; nd = 1'b1;
                end else if (pr) begin
                    np = 1'b1;
                end
            end else if (m_busy[i] && m_paused[i] && pr) begin
                np = 1'b0;
            end
            m_busy[i]   <= nb;
            m_paused[i] <= np;
            m_done[i]   <= nd;
            m_left[i]   <= nl;
        end
    end

    function automatic int expRemaining(int i);
        return m_busy[i] ? (m_left[i] + tpu[i] - 1) / tpu[i] : 0;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model busy T4",   int'(bus4.busy),      int'(m_busy[0]));
            checkOutput("model paused T4", int'(bus4.paused),    int'(m_paused[0]));
            checkOutput("model done T4",   int'(bus4.done),      int'(m_done[0]));
            checkOutput("model rem T4",    int'(bus4.remaining), expRemaining(0));
            checkOutput("model busy T1",   int'(bus1.busy),      int'(m_busy[1]));
            checkOutput("model paused T1", int'(bus1.paused),    int'(m_paused[1]));
            checkOutput("model done T1",   int'(bus1.done),      int'(m_done[1]));
            checkOutput("model rem T1",    int'(bus1.remaining), expRemaining(1));
        end
    end

    task automatic applyStimulus(input bit s, input int d, input bit p, input bit a, input bit r);
        st  = s;
        dur = CW'(d);
        pr  = p;
        ab  = a;
        rst = r;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic countDone(input int n);
        done_cnt = 0;
        repeat (n) begin
            idle(1);
            if (bus4.done) done_cnt++;
        end
        checkOutput("no done after abort", done_cnt, 0);
    endtask

    initial begin
        @(negedge clk);
        // Reset held three cycles with start asserted.
        repeat (3) applyStimulus(1, 3, 0, 0, 1);
        cmp_en = 1'b1;
        checkOutput("reset busy", int'(bus4.busy), 0);
        checkOutput("reset rem",  int'(bus4.remaining), 0);
        checkOutput("reset done", int'(bus4.done), 0);
        idle(1);
        checkOutput("post-reset busy", int'(bus4.busy), 0);

        // D=3, T=4 countdown.
        applyStimulus(1, 3, 0, 0, 0);
        checkOutput("run busy", int'(bus4.busy), 1);
        checkOutput("run rem k", int'(bus4.remaining), 3);
        idle(3);
        checkOutput("run rem k+3", int'(bus4.remaining), 3);
        idle(1);
        checkOutput("run rem k+4", int'(bus4.remaining), 2);
        idle(4);
        checkOutput("run rem k+8", int'(bus4.remaining), 1);
        idle(3);
        checkOutput("run done k+11", int'(bus4.done), 0);
        idle(1);
        checkOutput("run rem k+12",  int'(bus4.remaining), 0);
        checkOutput("run done k+12", int'(bus4.done), 1);
        checkOutput("run busy k+12", int'(bus4.busy), 0);
        idle(1);
        checkOutput("run done k+13", int'(bus4.done), 0);

        // Pause at k+3, resume at k+9, D=2.
        applyStimulus(1, 2, 0, 0, 0);
        idle(2);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("pause paused", int'(bus4.paused), 1);
        checkOutput("pause rem",    int'(bus4.remaining), 2);
        idle(5);
        checkOutput("pause held", int'(bus4.paused), 1);
        checkOutput("pause frozen rem", int'(bus4.remaining), 2);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("resume paused", int'(bus4.paused), 0);
        idle(4);
        checkOutput("pause done k+13", int'(bus4.done), 0);
        idle(1);
        checkOutput("pause done k+14", int'(bus4.done), 1);

        // Abort while running, then while paused.
        applyStimulus(1, 5, 0, 0, 0);
        idle(5);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("abort busy", int'(bus4.busy), 0);
        checkOutput("abort rem",  int'(bus4.remaining), 0);
        countDone(50);
        applyStimulus(1, 5, 0, 0, 0);
        idle(2);
        applyStimulus(0, 0, 1, 0, 0);
        idle(2);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("abort paused busy", int'(bus4.busy), 0);
        checkOutput("abort paused flag", int'(bus4.paused), 0);
        checkOutput("abort paused rem",  int'(bus4.remaining), 0);
        countDone(50);

        // Zero duration and restart.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("zero done", int'(bus4.done), 1);
        checkOutput("zero busy", int'(bus4.busy), 0);
        idle(1);
        checkOutput("zero done after", int'(bus4.done), 0);
        checkOutput("zero busy after", int'(bus4.busy), 0);
        applyStimulus(1, 4, 0, 0, 0);
        idle(4);
        applyStimulus(1, 2, 0, 0, 0);
        checkOutput("restart rem", int'(bus4.remaining), 2);
        idle(7);
        checkOutput("restart done early", int'(bus4.done), 0);
        idle(1);
        checkOutput("restart done", int'(bus4.done), 1);
        idle(2);

        // Collisions on the T=1 instance.
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("t1 busy", int'(bus1.busy), 1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("expiry+pause done",   int'(bus1.done), 1);
        checkOutput("expiry+pause busy",   int'(bus1.busy), 0);
        checkOutput("expiry+pause paused", int'(bus1.paused), 0);
        applyStimulus(1, 5, 0, 1, 0);
        checkOutput("abort+start busy", int'(bus1.busy), 0);
        checkOutput("abort+start done", int'(bus1.done), 0);
        idle(1);
        checkOutput("abort+start done next", int'(bus1.done), 0);
        applyStimulus(1, 5, 0, 0, 0);
        idle(1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("rst mid-run busy", int'(bus1.busy), 0);
        checkOutput("rst mid-run rem",  int'(bus1.remaining), 0);
        checkOutput("rst mid-run done", int'(bus1.done), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            automatic int r = $urandom_range(0, 199);
            automatic int d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            applyStimulus(r < 10, d, (r >= 20) && (r < 34), (r >= 10) && (r < 14), r == 199);
        end
        idle(30);
        cmp_en = 1'b0;
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
